// File: rtl/multi_led_driver.sv
// Multi-channel LED driver: shared prescaler, programmable step period, blink/alternate/chase/PWM modes.
// Optional breathing ramp for the PWM mode is built when MULTI_LED_DRIVER_BREATHE_EN is defined.
module multi_led_driver #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned PRESCALE  = 25000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic [1:0]           MODE,
  input  logic [CNT_WIDTH-1:0] PERIOD,
  input  logic [7:0]           DUTY,
  output logic [NUM_CH-1:0]    Q,
  output logic [NUM_CH-1:0]    not_Q,
  output logic                 TICK
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned PTR_W = $clog2(NUM_CH);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    MODE_BLINK = 2'd0,
    MODE_ALT   = 2'd1,
    MODE_CHASE = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [PRE_W-1:0]     pre_cnt;
  logic [CNT_WIDTH-1:0] step_cnt;
  logic [CNT_WIDTH-1:0] pm_m1;
  logic                 phase;
  logic [PTR_W-1:0]     ptr;
  logic [7:0]           pwm_cnt;
  logic [7:0]           duty_eff;
  logic                 tick_c;
  logic                 step_evt;
  logic [NUM_CH-1:0]    q_next;
  logic [NUM_CH-1:0]    one_hot_base;

  // Tick is decoded from the registered prescaler count and forced low while reset is held
  assign tick_c   = EN && (pre_cnt == PRE_MAX);
  assign TICK     = tick_c && !RST;
  assign pm_m1    = (PERIOD == '0) ? '0 : PERIOD - CNT_WIDTH'(1);
  // >= so that a shrinking PERIOD fires on the next tick instead of wrapping the counter
  assign step_evt = tick_c && (step_cnt >= pm_m1);

  assign one_hot_base = NUM_CH'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_cnt  <= '0;
      step_cnt <= '0;
      phase    <= 1'b0;
      ptr      <= '0;
      pwm_cnt  <= '0;
      Q        <= '0;
      not_Q    <= '1;
    end else if (EN) begin
      pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + PRE_W'(1);
      pwm_cnt <= pwm_cnt + 8'd1;
      if (tick_c) begin
        step_cnt <= step_evt ? '0 : step_cnt + CNT_WIDTH'(1);
      end
      if (step_evt) begin
        phase <= ~phase;
        ptr   <= (ptr == PTR_MAX) ? '0 : ptr + PTR_W'(1);
      end
      Q     <= q_next;
      not_Q <= ~q_next;
    end
  end

`ifdef MULTI_LED_DRIVER_BREATHE_EN
  logic [7:0] ramp;
  logic       ramp_up;
  logic       unused_duty;

  assign unused_duty = ^DUTY;
  assign duty_eff    = ramp;

  // Triangle ramp: each endpoint is held for exactly one step before reversing
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ramp    <= 8'd0;
      ramp_up <= 1'b1;
    end else if (EN && step_evt) begin
      if (ramp_up) begin
        if (ramp == 8'd255) begin
          ramp    <= 8'd254;
          ramp_up <= 1'b0;
        end else begin
          ramp <= ramp + 8'd1;
        end
      end else begin
        if (ramp == 8'd0) begin
          ramp    <= 8'd1;
          ramp_up <= 1'b1;
        end else begin
          ramp <= ramp - 8'd1;
        end
      end
    end
  end
`else
  assign duty_eff = DUTY;
`endif

  // Next output pattern from current state; registered above, so outputs lag state by one cycle
  always_comb begin
    q_next = '0;
    case (mode_e'(MODE))
      MODE_BLINK: q_next = {NUM_CH{phase}};
      MODE_ALT: begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
          q_next[i] = phase ^ 1'(i % 2);
        end
      end
      MODE_CHASE: q_next = one_hot_base << ptr;
      MODE_PWM:   q_next = {NUM_CH{pwm_cnt < duty_eff}};
      default:    q_next = '0;
    endcase
  end

endmodule

// File: doc/multi_led_driver.md
Name: multi_led_driver

Overview:
- Parametrised successor to the single-channel CLK -> Q/not_Q test IC used for LED bring-up boards.
- Drives NUM_CH LED channels from one board oscillator clock, with complementary outputs per channel.
- Has a shared prescaler, a programmable step period and four run-time modes: in-phase blink, alternate blink, chase and PWM dim.
- Sits between the oscillator net and the LED anode nets of the test netlist.

Parameters:
NUM_CH, 4, number of LED channels (2..16)
PRESCALE, 25000, CLK cycles per TICK (>=1)
CNT_WIDTH, 16, width of PERIOD and of the step counter

Ports:
CLK  in  1  board oscillator clock; all state on rising edge
RST  in  1  asynchronous, active-high reset
EN  in  1  run enable; low freezes all counters and outputs
MODE  in  2  0=in-phase blink, 1=alternate blink, 2=chase, 3=PWM dim
PERIOD  in  CNT_WIDTH  TICKs per step event; 0 treated as 1
DUTY  in  8  PWM on-count out of 256 (mode 3)
Q  out  NUM_CH  channel drive, registered
not_Q  out  NUM_CH  bitwise complement of Q, registered
TICK  out  1  one-cycle prescaler pulse

Behaviour:
- Reset: one clock, CLK; reset RST is asynchronous, active-high. While RST is high all state clears immediately:
  - pre_cnt=0, step_cnt=0, phase=0, ptr=0, pwm_cnt=0
  - Q=0, not_Q=all ones, TICK=0
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps while EN=1.
  - TICK=1 when pre_cnt==PRESCALE-1 and EN=1, decoded from the registered count.
  - PRESCALE=1 gives TICK high on every enabled cycle.
- Step counter: on TICK, step_cnt increments.
  - step event = TICK and step_cnt==Pm-1, where Pm=max(PERIOD,1). On a step event step_cnt clears.
  - A PERIOD change takes effect at the next compare. If step_cnt>=Pm-1 when PERIOD shrinks, the next TICK is a step event.
- Step event updates:
  - phase toggles.
  - ptr increments and wraps NUM_CH-1 -> 0.
- PWM: pwm_cnt is a free-running 8-bit counter that increments every enabled CLK and wraps 255 -> 0.
- Output decode: next Q is computed from the current state and registered, so outputs lag the state update by 1 cycle.
  - Mode 0: all bits = phase.
  - Mode 1: Q[i] = phase XOR (i odd).
  - Mode 2: one-hot at ptr.
  - Mode 3: all bits = (pwm_cnt < DUTY). DUTY=0 keeps Q always low; DUTY=255 gives 255 of 256 cycles high.
- not_Q = ~Q at all times, including reset.
- EN=0: all counters, phase, ptr, Q and not_Q hold; TICK=0. When EN returns, counting resumes from the held values.
- MODE change: applies at the next output register update. Counters, phase and ptr are not reset.
- RST mid-operation: outputs clear asynchronously. After release, the first TICK arrives after PRESCALE enabled cycles.

Optional Feature:
- Macro: MULTI_LED_DRIVER_BREATHE_EN.
- Defined:
  - Mode 3 uses an internal 8-bit ramp instead of DUTY.
  - On each step event the ramp steps by 1 in its current direction, climbing 0 -> 255 then descending 255 -> 0.
  - The direction reverses at each end; each endpoint value is held for exactly one step.
  - Reset: ramp=0, direction=up. DUTY is ignored.
- Undefined: no ramp logic is built, and mode 3 uses DUTY directly.

Test Plan (NUM_CH=4, PRESCALE=4, PERIOD=3 unless stated):
1. Assert RST asynchronously mid-run, between CLK edges -> Q=0000, not_Q=1111 and TICK=0 before the next edge. After release, TICK first pulses on the 4th enabled cycle.
2. MODE=0, EN=1 -> TICK every 4 clocks. Q alternates 1111 / 0000, each level lasting 12 clocks, with not_Q always the complement. Repeat with MODE=1 -> Q alternates 1010 / 0101.
3. MODE=2 -> Q sequence 0001, 0010, 0100, 1000, 0001, each lasting 12 clocks, showing ptr wrap.
4. MODE=3, DUTY=64 -> Q high for exactly 64 of every 256 clocks. DUTY=0 -> Q never high. DUTY=255 -> Q low for 1 of 256 clocks.
5. EN=0 for 20 clocks mid-step -> Q, not_Q and counters frozen, TICK=0. After EN=1 the remaining step time completes with no lost or extra TICK.
6. PERIOD=0 -> step every TICK (Q toggles every 4 clocks). With BREATHE_EN, mode 3: the effective duty ramps 0..255..0 over 510 step events.
